hazard_controller: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage (F/D/E/M/WB) processor, sitting beside the opcode decoder. It produces stall/flush/forwarding controls from the register addresses and write enables the decoder pipes down each stage. It owns a one-entry buffered handshake for the OUT instruction (decoder `outFlag`) and keeps saturating hazard performance counters.

---
 rtl/hazard_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_hazard_controller.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Hazard and sequencing controller for the 5-stage (F/D/E/M/WB) pipeline.
// It sits beside the opcode decoder and derives the stall, flush and
// forwarding controls from the register addresses and write enables that the
// decoder pipes down each stage. It also holds a one-entry buffer for the OUT
// instruction, with a valid/ready handshake, and keeps two saturating hazard
// performance counters.
//
// Ports
//   clk                         clock, all state changes on the rising edge
//   reset                       synchronous, active-low reset
//   regSrc1D/regSrc2D           source registers of the instruction in D
//   usesSrc1D/usesSrc2D         instruction in D really reads src1/src2
//   regSrc1E/regSrc2E           source registers of the instruction in E
//   regDestE/M/W                destination register per stage
//   writeEnableE/M/W            register write enable per stage
//   memToRegE                   instruction in E is a load
//   branchTakenE                branch resolved taken in E
//   outFlagE/outDataE           OUT instruction and its operand in E
//   outReady                    external consumer accepts outData
//   perfClear                   zero both performance counters
//   stallF/stallD/stallE        hold stage registers (combinational)
//   flushD/flushE               bubble into D/E registers (combinational)
//   forwardAE/forwardBE         operand select: 00 regfile, 10 M, 01 WB
//   outValid/outData            buffered OUT value (registered)
//   stallCycles/flushEvents     saturating performance counters
// -----------------------------------------------------------------------------
module hazard_controller #(
    parameter int REGADDRWIDTH = 4,
    parameter int DATAWIDTH    = 16,
    parameter int CNTWIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [REGADDRWIDTH-1:0] regSrc1D,
    input  logic [REGADDRWIDTH-1:0] regSrc2D,
    input  logic                    usesSrc1D,
    input  logic                    usesSrc2D,
    input  logic [REGADDRWIDTH-1:0] regSrc1E,
    input  logic [REGADDRWIDTH-1:0] regSrc2E,
    input  logic [REGADDRWIDTH-1:0] regDestE,
    input  logic [REGADDRWIDTH-1:0] regDestM,
    input  logic [REGADDRWIDTH-1:0] regDestW,
    input  logic                    writeEnableE,
    input  logic                    writeEnableM,
    input  logic                    writeEnableW,
    input  logic                    memToRegE,
    input  logic                    branchTakenE,
    input  logic                    outFlagE,
    input  logic [DATAWIDTH-1:0]    outDataE,
    input  logic                    outReady,
    input  logic                    perfClear,
    output logic                    stallF,
    output logic                    stallD,
    output logic                    stallE,
    output logic                    flushD,
    output logic                    flushE,
    output logic [1:0]              forwardAE,
    output logic [1:0]              forwardBE,
    output logic                    outValid,
    output logic [DATAWIDTH-1:0]    outData,
    output logic [CNTWIDTH-1:0]     stallCycles,
    output logic [CNTWIDTH-1:0]     flushEvents
);

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_FULL = 1'b1
    } out_state_t;

    out_state_t            r_state;
    out_state_t            w_stateNext;
    logic [DATAWIDTH-1:0]  r_outData;
    logic [DATAWIDTH-1:0]  w_outDataNext;
    logic [CNTWIDTH-1:0]   r_stallCycles;
    logic [CNTWIDTH-1:0]   r_flushEvents;

    logic                  w_fsmFull;
    logic                  w_loadUse;
    logic                  w_outStall;
    logic                  w_src1Hit;
    logic                  w_src2Hit;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNTWIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand bypass select for one E-stage source; the M stage holds the
    // younger result, so it is checked first.
    function automatic logic [1:0] fwd_sel(
        input logic [REGADDRWIDTH-1:0] src,
        input logic                    weM,
        input logic [REGADDRWIDTH-1:0] dstM,
        input logic                    weW,
        input logic [REGADDRWIDTH-1:0] dstW
    );
        if (weM && (dstM == src)) begin
            return 2'b10;
        end
        if (weW && (dstW == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // -------------------------------------------------------------------------
    // Hazard detection (combinational)
    // -------------------------------------------------------------------------

    // While reset is asserted the buffer is about to be discarded, so the
    // combinational logic treats it as empty.
    assign w_fsmFull  = reset && (r_state == OUT_FULL);

    // Every register address takes part in the compare; register 0 is not
    // special in this machine.
    assign w_src1Hit  = usesSrc1D && (regSrc1D == regDestE);
    assign w_src2Hit  = usesSrc2D && (regSrc2D == regDestE);
    assign w_loadUse  = memToRegE && writeEnableE && (w_src1Hit || w_src2Hit);

    // A second OUT arriving while the buffer is still unconsumed must wait in E.
    assign w_outStall = w_fsmFull && outFlagE && !outReady;

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (branchTakenE) begin
            // Wrong-path instructions in D and E are squashed; nothing stalls.
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (w_outStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
        end else if (w_loadUse) begin
            // Hold F/D and let a bubble advance into E until the load reaches M.
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    assign forwardAE = fwd_sel(regSrc1E, writeEnableM, regDestM, writeEnableW, regDestW);
    assign forwardBE = fwd_sel(regSrc2E, writeEnableM, regDestM, writeEnableW, regDestW);

    // -------------------------------------------------------------------------
    // OUT buffer FSM: next state and buffer contents
    // -------------------------------------------------------------------------
    always_comb begin
        w_stateNext   = r_state;
        w_outDataNext = r_outData;
        unique case (r_state)
            OUT_IDLE: begin
                if (outFlagE) begin
                    w_stateNext   = OUT_FULL;
                    w_outDataNext = outDataE;
                end
            end
            OUT_FULL: begin
                if (outReady) begin
                    // Current value is consumed this edge; a waiting OUT
                    // refills the slot in the same cycle.
                    if (outFlagE) begin
                        w_outDataNext = outDataE;
                    end else begin
                        w_stateNext   = OUT_IDLE;
                    end
                end
                // Not ready: keep the value stable; any new OUT is stalled.
            end
            default: begin
                w_stateNext = OUT_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= OUT_IDLE;
            r_outData <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_outData <= w_outDataNext;
        end
    end

    // Performance counters; clear takes precedence over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stallCycles <= '0;
            r_flushEvents <= '0;
        end else if (perfClear) begin
            r_stallCycles <= '0;
            r_flushEvents <= '0;
        end else begin
            if (stallF) begin
                r_stallCycles <= sat_inc(r_stallCycles);
            end
            if (branchTakenE) begin
                r_flushEvents <= sat_inc(r_flushEvents);
            end
        end
    end

    assign outValid    = (r_state == OUT_FULL);
    assign outData     = r_outData;
    assign stallCycles = r_stallCycles;
    assign flushEvents = r_flushEvents;

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
//
// Self-checking bench for hazard_controller. The counters are built 4 bits
// wide so saturation is reached in a handful of cycles. A behavioural model
// (one-slot buffer plus integer counters clamped at the maximum) tracks the
// expected state; directed tasks check literal values, the random task checks
// against the model every cycle.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] regSrc1D, regSrc2D, regSrc1E, regSrc2E;
    logic [AW-1:0] regDestE, regDestM, regDestW;
    logic          usesSrc1D, usesSrc2D;
    logic          writeEnableE, writeEnableM, writeEnableW;
    logic          memToRegE, branchTakenE, outFlagE, outReady, perfClear;
    logic [DW-1:0] outDataE;
    logic          stallF, stallD, stallE, flushD, flushE;
    logic [1:0]    forwardAE, forwardBE;
    logic          outValid;
    logic [DW-1:0] outData;
    logic [CW-1:0] stallCycles, flushEvents;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_full;
    logic [DW-1:0] m_data;
    int            m_stall;
    int            m_flush;

    always #5 clk = ~clk;

    hazard_controller #(
        .REGADDRWIDTH(AW),
        .DATAWIDTH   (DW),
        .CNTWIDTH    (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .regSrc1D    (regSrc1D),
        .regSrc2D    (regSrc2D),
        .usesSrc1D   (usesSrc1D),
        .usesSrc2D   (usesSrc2D),
        .regSrc1E    (regSrc1E),
        .regSrc2E    (regSrc2E),
        .regDestE    (regDestE),
        .regDestM    (regDestM),
        .regDestW    (regDestW),
        .writeEnableE(writeEnableE),
        .writeEnableM(writeEnableM),
        .writeEnableW(writeEnableW),
        .memToRegE   (memToRegE),
        .branchTakenE(branchTakenE),
        .outFlagE    (outFlagE),
        .outDataE    (outDataE),
        .outReady    (outReady),
        .perfClear   (perfClear),
        .stallF      (stallF),
        .stallD      (stallD),
        .stallE      (stallE),
        .flushD      (flushD),
        .flushE      (flushE),
        .forwardAE   (forwardAE),
        .forwardBE   (forwardBE),
        .outValid    (outValid),
        .outData     (outData),
        .stallCycles (stallCycles),
        .flushEvents (flushEvents)
    );

    // Observed {stallF, stallD, stallE, flushD, flushE}
    function automatic logic [4:0] hz();
        return {stallF, stallD, stallE, flushD, flushE};
    endfunction

    // Expected {stallF, stallD, stallE, flushD, flushE} from the priority rules.
    function automatic logic [4:0] exp_hz();
        bit ld;
        bit os;
        ld = memToRegE && writeEnableE &&
             ((usesSrc1D && regSrc1D == regDestE) || (usesSrc2D && regSrc2D == regDestE));
        os = reset && m_full && outFlagE && !outReady;
        if (branchTakenE) return 5'b00011;
        if (os)           return 5'b11100;
        if (ld)           return 5'b11001;
        return 5'b00000;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] s);
        if (writeEnableM && regDestM == s) return 2'b10;
        if (writeEnableW && regDestW == s) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        reset = 1'b1;
        regSrc1D = '0; regSrc2D = '0; regSrc1E = '0; regSrc2E = '0;
        regDestE = '0; regDestM = '0; regDestW = '0;
        usesSrc1D = 1'b0; usesSrc2D = 1'b0;
        writeEnableE = 1'b0; writeEnableM = 1'b0; writeEnableW = 1'b0;
        memToRegE = 1'b0; branchTakenE = 1'b0; outFlagE = 1'b0;
        outReady = 1'b0; perfClear = 1'b0; outDataE = '0;
    endtask

    // One clock edge; the model consumes the inputs present at that edge.
    task automatic tick();
        logic [4:0] h;
        h = exp_hz();
        @(posedge clk);
        if (!reset) begin
            m_full = 1'b0; m_data = '0; m_stall = 0; m_flush = 0;
        end else begin
            if (perfClear) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (h[4] && m_stall < MAXC) m_stall++;
                if (branchTakenE && m_flush < MAXC) m_flush++;
            end
            if (outFlagE && (!m_full || outReady)) begin
                m_full = 1'b1; m_data = outDataE;
            end else if (m_full && outReady) begin
                m_full = 1'b0;
            end
        end
        #1;
    endtask

    task automatic load_use_r3();
        memToRegE = 1'b1; writeEnableE = 1'b1; regDestE = 4'd3;
        regSrc2D = 4'd3; usesSrc2D = 1'b1; regSrc1D = 4'd7; usesSrc1D = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_outValid got %b exp 0", outValid); end
        checks++; if (outData !== 16'h0) begin errors++; $display("FAIL rst_outData got %h exp 0000", outData); end
        checks++; if (stallCycles !== 4'h0 || flushEvents !== 4'h0) begin errors++; $display("FAIL rst_counters got %h/%h exp 0/0", stallCycles, flushEvents); end
        checks++; if (hz() !== 5'b00000) begin errors++; $display("FAIL rst_hazard got %b exp 00000", hz()); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        load_use_r3();
        #1;
        checks++; if (hz() !== 5'b11001) begin errors++; $display("FAIL loaduse_src2 got %b exp 11001", hz()); end
        tick();
        idle_inputs();
        #1;
        checks++; if (stallCycles !== 4'h1) begin errors++; $display("FAIL loaduse_count got %h exp 1", stallCycles); end
        checks++; if (hz() !== 5'b00000) begin errors++; $display("FAIL loaduse_clear got %b exp 00000", hz()); end
        memToRegE = 1'b1; writeEnableE = 1'b1; regDestE = 4'd9; regSrc1D = 4'd9;
        usesSrc1D = 1'b0;
        #1;
        checks++; if (hz() !== 5'b00000) begin errors++; $display("FAIL loaduse_unused_src got %b exp 00000", hz()); end
        usesSrc1D = 1'b1;
        #1;
        checks++; if (hz() !== 5'b11001) begin errors++; $display("FAIL loaduse_src1 got %b exp 11001", hz()); end
        memToRegE = 1'b0;
        #1;
        checks++; if (hz() !== 5'b00000) begin errors++; $display("FAIL loaduse_notload got %b exp 00000", hz()); end
        idle_inputs();
    endtask

    task automatic test_forwarding();
        idle_inputs();
        writeEnableM = 1'b1; regDestM = 4'd5; writeEnableW = 1'b1; regDestW = 4'd5;
        regSrc1E = 4'd5; regSrc2E = 4'd6;
        #1;
        checks++; if (forwardAE !== 2'b10) begin errors++; $display("FAIL fwdA_M got %b exp 10", forwardAE); end
        checks++; if (forwardBE !== 2'b00) begin errors++; $display("FAIL fwdB_none got %b exp 00", forwardBE); end
        writeEnableM = 1'b0;
        #1;
        checks++; if (forwardAE !== 2'b01) begin errors++; $display("FAIL fwdA_W got %b exp 01", forwardAE); end
        regSrc2E = 4'd5;
        #1;
        checks++; if (forwardBE !== 2'b01) begin errors++; $display("FAIL fwdB_W got %b exp 01", forwardBE); end
        writeEnableW = 1'b0;
        #1;
        checks++; if (forwardAE !== 2'b00) begin errors++; $display("FAIL fwdA_off got %b exp 00", forwardAE); end
        writeEnableM = 1'b1; regDestM = 4'd0; regSrc2E = 4'd0;
        #1;
        checks++; if (forwardBE !== 2'b10) begin errors++; $display("FAIL fwdB_r0 got %b exp 10", forwardBE); end
        idle_inputs();
    endtask

    task automatic test_out_handshake();
        int s0;
        idle_inputs();
        tick();
        s0 = m_stall;
        outFlagE = 1'b1; outDataE = 16'h00AB; outReady = 1'b0;
        #1;
        checks++; if (hz() !== 5'b00000 || outValid !== 1'b0) begin errors++; $display("FAIL out_first got hz=%b v=%b exp 00000/0", hz(), outValid); end
        tick();
        outFlagE = 1'b0;
        #1;
        checks++; if (outValid !== 1'b1 || outData !== 16'h00AB) begin errors++; $display("FAIL out_capture got %b/%h exp 1/00ab", outValid, outData); end
        outFlagE = 1'b1; outDataE = 16'h00CD;
        #1;
        checks++; if (hz() !== 5'b11100) begin errors++; $display("FAIL out_stall1 got %b exp 11100", hz()); end
        tick();
        #1;
        checks++; if (hz() !== 5'b11100 || outData !== 16'h00AB) begin errors++; $display("FAIL out_stall2 got %b/%h exp 11100/00ab", hz(), outData); end
        tick();
        outReady = 1'b1;
        #1;
        checks++; if (hz() !== 5'b00000 || outData !== 16'h00AB) begin errors++; $display("FAIL out_release got %b/%h exp 00000/00ab", hz(), outData); end
        tick();
        outFlagE = 1'b0; outReady = 1'b0;
        #1;
        checks++; if (outValid !== 1'b1 || outData !== 16'h00CD) begin errors++; $display("FAIL out_second got %b/%h exp 1/00cd", outValid, outData); end
        checks++; if (stallCycles !== 4'(s0 + 2)) begin errors++; $display("FAIL out_stallcount got %0d exp %0d", stallCycles, s0 + 2); end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        #1;
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL out_drain got %b exp 0", outValid); end
        idle_inputs();
    endtask

    task automatic test_priority();
        int s0;
        int f0;
        idle_inputs();
        load_use_r3();
        branchTakenE = 1'b1;
        #1;
        checks++; if (hz() !== 5'b00011) begin errors++; $display("FAIL prio_branch got %b exp 00011", hz()); end
        s0 = m_stall; f0 = m_flush;
        tick();
        idle_inputs();
        #1;
        checks++; if (flushEvents !== 4'(f0 + 1) || stallCycles !== 4'(s0)) begin errors++; $display("FAIL prio_counts got %0d/%0d exp %0d/%0d", flushEvents, stallCycles, f0 + 1, s0); end
        outFlagE = 1'b1; outDataE = 16'h0011;
        tick();
        load_use_r3();
        outDataE = 16'h0022;
        #1;
        checks++; if (hz() !== 5'b11100) begin errors++; $display("FAIL prio_out_over_load got %b exp 11100", hz()); end
        idle_inputs();
        outReady = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_saturation();
        idle_inputs();
        perfClear = 1'b1;
        tick();
        perfClear = 1'b0;
        load_use_r3();
        repeat (MAXC - 1) tick();
        #1;
        checks++; if (stallCycles !== 4'(MAXC - 1)) begin errors++; $display("FAIL sat_preset got %h exp %h", stallCycles, MAXC - 1); end
        repeat (3) tick();
        #1;
        checks++; if (stallCycles !== 4'(MAXC)) begin errors++; $display("FAIL sat_stick got %h exp %h", stallCycles, MAXC); end
        perfClear = 1'b1; branchTakenE = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++; if (stallCycles !== 4'h0 || flushEvents !== 4'h0) begin errors++; $display("FAIL sat_clear got %h/%h exp 0/0", stallCycles, flushEvents); end
    endtask

    task automatic test_back_to_back();
        int s0;
        idle_inputs();
        s0 = m_stall;
        outReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            outFlagE = 1'b1; outDataE = 16'(16'h1000 + i);
            #1;
            checks++; if (hz() !== 5'b00000) begin errors++; $display("FAIL b2b_stall%0d got %b exp 00000", i, hz()); end
            if (i > 0) begin
                checks++; if (outValid !== 1'b1 || outData !== 16'(16'h1000 + i - 1)) begin errors++; $display("FAIL b2b_data%0d got %b/%h exp 1/%h", i, outValid, outData, 16'(16'h1000 + i - 1)); end
            end
            tick();
        end
        outFlagE = 1'b0;
        #1;
        checks++; if (outData !== 16'h1005) begin errors++; $display("FAIL b2b_last got %h exp 1005", outData); end
        tick();
        #1;
        checks++; if (outValid !== 1'b0 || stallCycles !== 4'(s0)) begin errors++; $display("FAIL b2b_end got %b/%0d exp 0/%0d", outValid, stallCycles, s0); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_handshake();
        idle_inputs();
        outFlagE = 1'b1; outDataE = 16'h005A; branchTakenE = 1'b1;
        tick();
        branchTakenE = 1'b0; outDataE = 16'h005B;
        reset = 1'b0;
        #1;
        checks++; if (hz() !== 5'b00000) begin errors++; $display("FAIL rstmid_hazard got %b exp 00000", hz()); end
        tick();
        reset = 1'b1; outFlagE = 1'b0;
        #1;
        checks++; if (outValid !== 1'b0 || outData !== 16'h0) begin errors++; $display("FAIL rstmid_out got %b/%h exp 0/0000", outValid, outData); end
        checks++; if (stallCycles !== 4'h0 || flushEvents !== 4'h0) begin errors++; $display("FAIL rstmid_counters got %h/%h exp 0/0", stallCycles, flushEvents); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 2000; n++) begin
            reset        = ($urandom_range(0, 63) != 0);
            regSrc1D     = 4'($urandom_range(0, 3));
            regSrc2D     = 4'($urandom_range(0, 3));
            regSrc1E     = 4'($urandom_range(0, 3));
            regSrc2E     = 4'($urandom_range(0, 3));
            regDestE     = 4'($urandom_range(0, 3));
            regDestM     = 4'($urandom_range(0, 3));
            regDestW     = 4'($urandom_range(0, 3));
            usesSrc1D    = 1'($urandom_range(0, 1));
            usesSrc2D    = 1'($urandom_range(0, 1));
            writeEnableE = 1'($urandom_range(0, 1));
            writeEnableM = 1'($urandom_range(0, 1));
            writeEnableW = 1'($urandom_range(0, 1));
            memToRegE    = 1'($urandom_range(0, 1));
            branchTakenE = ($urandom_range(0, 7) == 0);
            outFlagE     = 1'($urandom_range(0, 1));
            outDataE     = 16'($urandom);
            outReady     = 1'($urandom_range(0, 1));
            perfClear    = ($urandom_range(0, 31) == 0);
            #1;
            checks++; if (hz() !== exp_hz()) begin errors++; $display("FAIL rnd_hazard n=%0d got %b exp %b", n, hz(), exp_hz()); end
            checks++; if (forwardAE !== exp_fwd(regSrc1E) || forwardBE !== exp_fwd(regSrc2E)) begin errors++; $display("FAIL rnd_fwd n=%0d got %b/%b exp %b/%b", n, forwardAE, forwardBE, exp_fwd(regSrc1E), exp_fwd(regSrc2E)); end
            checks++; if (outValid !== m_full || (m_full && outData !== m_data)) begin errors++; $display("FAIL rnd_out n=%0d got %b/%h exp %b/%h", n, outValid, outData, m_full, m_data); end
            checks++; if (stallCycles !== 4'(m_stall) || flushEvents !== 4'(m_flush)) begin errors++; $display("FAIL rnd_counters n=%0d got %0d/%0d exp %0d/%0d", n, stallCycles, flushEvents, m_stall, m_flush); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        m_full = 1'b0; m_data = '0; m_stall = 0; m_flush = 0;
        idle_inputs();
        #2;
        test_reset();
        test_load_use();
        test_forwarding();
        test_out_handshake();
        test_priority();
        test_saturation();
        test_back_to_back();
        test_reset_mid_handshake();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
